// File: rtl/apple2_kbd_ctrl.sv
// Apple II keyboard controller: debounces the USB keycode, drives the encoder and
// manages the $C000/$C010 strobe and any-key-down flags. Optional macro: KBD_AUTOREPEAT_EN.
module apple2_kbd_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic [7:0] enc_keycode,
    input  logic [6:0] enc_ascii,
    input  logic       strb_clr,
    output logic [7:0] kbd_data,
    output logic       kstrb,
    output logic       akd
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PRESS_DB  = 2'd1;
    localparam logic [1:0] S_HELD      = 2'd2;
    localparam logic [1:0] S_CHANGE_DB = 2'd3;

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic is_supported(input logic [7:0] code);
        return ((code >= 8'd4) && (code <= 8'd44)) || ((code >= 8'd79) && (code <= 8'd82));
    endfunction

    logic [1:0]      state;
    logic [1:0]      state_d;
    logic [7:0]      cand;
    logic [DB_W-1:0] db_cnt;
    logic [7:0]      held_code;
    logic [7:0]      held_d;
    logic [6:0]      ascii;
    logic            akd_d;
    logic            latch_c;
    logic            set_strb_c;
    logic            cand_match_c;
    logic            commit_c;

    assign enc_keycode  = cand;
    assign kbd_data     = {kstrb, ascii};
    assign cand_match_c = (keycode == cand);
    assign commit_c     = cand_match_c && (db_cnt == DB_LAST);

`ifdef KBD_AUTOREPEAT_EN
    localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RP_W   = $clog2(RP_MAX);
    localparam logic [RP_W-1:0] RP_DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

    logic [RP_W-1:0] rep_cnt;
    logic            rep_first;
    logic            rep_fire_c;
    logic            rep_inc_c;
    logic            rep_clr_c;
    logic [RP_W-1:0] rep_target_c;

    assign rep_target_c = rep_first ? RP_DELAY_LAST : RP_PERIOD_LAST;
    // A strobe outside HELD is always a fresh commit, which restarts the repeat timing.
    assign rep_clr_c    = set_strb_c && (state != S_HELD);
`endif

    // Candidate register and stable-cycle counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cand   <= 8'd0;
            db_cnt <= '0;
        end else if (!cand_match_c) begin
            cand   <= keycode;
            db_cnt <= '0;
        end else if (db_cnt != DB_LAST) begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Next-state and commit decisions.
    always_comb begin
        state_d    = state;
        held_d     = held_code;
        akd_d      = akd;
        latch_c    = 1'b0;
        set_strb_c = 1'b0;
`ifdef KBD_AUTOREPEAT_EN
        rep_fire_c = 1'b0;
        rep_inc_c  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                akd_d = 1'b0;
                if (is_supported(cand)) state_d = S_PRESS_DB;
            end
            S_PRESS_DB: begin
                if (!is_supported(cand)) begin
                    state_d = S_IDLE;
                end else if (commit_c) begin
                    latch_c    = 1'b1;
                    set_strb_c = 1'b1;
                    akd_d      = 1'b1;
                    held_d     = cand;
                    state_d    = S_HELD;
                end
            end
            S_HELD: begin
                akd_d = 1'b1;
                if (cand != held_code) begin
                    state_d = S_CHANGE_DB;
                end else begin
`ifdef KBD_AUTOREPEAT_EN
                    if (rep_cnt == rep_target_c) begin
                        rep_fire_c = 1'b1;
                        latch_c    = 1'b1;
                        set_strb_c = 1'b1;
                    end else begin
                        rep_inc_c = 1'b1;
                    end
`endif
                end
            end
            default: begin
                akd_d = 1'b1;
                if (keycode == held_code) begin
                    state_d = S_HELD;
                end else if (commit_c) begin
                    if (is_supported(cand)) begin
                        latch_c    = 1'b1;
                        set_strb_c = 1'b1;
                        held_d     = cand;
                        state_d    = S_HELD;
                    end else begin
                        akd_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            held_code <= 8'd0;
            ascii     <= 7'd0;
            kstrb     <= 1'b0;
            akd       <= 1'b0;
        end else begin
            state     <= state_d;
            held_code <= held_d;
            akd       <= akd_d;
            if (latch_c) ascii <= enc_ascii;
            // A new strobe wins over a same-edge clear.
            if (set_strb_c)    kstrb <= 1'b1;
            else if (strb_clr) kstrb <= 1'b0;
        end
    end

`ifdef KBD_AUTOREPEAT_EN
    // Repeat timer: counts only in HELD, frozen elsewhere, restarted on commit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (rep_clr_c) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (rep_fire_c) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else if (rep_inc_c && (rep_cnt != {RP_W{1'b1}})) begin
            rep_cnt <= rep_cnt + RP_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_apple2_kbd_ctrl.sv
// Directed self-checking bench for apple2_kbd_ctrl with short debounce/repeat timing.
module tb_apple2_kbd_ctrl;

    localparam int unsigned DB = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic [7:0] enc_keycode;
    logic [6:0] enc_ascii;
    logic       strb_clr;
    logic [7:0] kbd_data;
    logic       kstrb;
    logic       akd;

    int checks = 0;
    int errors = 0;

    apple2_kbd_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .enc_keycode(enc_keycode),
        .enc_ascii  (enc_ascii),
        .strb_clr   (strb_clr),
        .kbd_data   (kbd_data),
        .kstrb      (kstrb),
        .akd        (akd)
    );

    always #5 Clk = ~Clk;

    // Stand-in for the keyboard encoder ROM.
    function automatic logic [6:0] ascii_of(input logic [7:0] c);
        logic [7:0] t;
        if (c >= 8'd4 && c <= 8'd29)       t = 8'h41 + (c - 8'd4);
        else if (c >= 8'd30 && c <= 8'd38) t = 8'h31 + (c - 8'd30);
        else if (c == 8'd39)               t = 8'h30;
        else if (c == 8'd40)               t = 8'h0D;
        else if (c == 8'd44)               t = 8'h20;
        else                               t = 8'h00;
        return t[6:0];
    endfunction

    assign enc_ascii = ascii_of(enc_keycode);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_strobe();
        strb_clr = 1'b1;
        tick();
        strb_clr = 1'b0;
    endtask

    // Drive a code and wait through load edge plus DB stable edges.
    task automatic settle(input logic [7:0] code);
        keycode = code;
        ticks(DB + 1);
    endtask

    int rep_edges[$];
    logic akd_dropped;

    initial begin
        Reset    = 1'b1;
        keycode  = 8'd0;
        strb_clr = 1'b0;
        ticks(3);
        check("rst_kbd_data", 32'(kbd_data), 32'h00);
        check("rst_kstrb", 32'(kstrb), 32'h0);
        check("rst_akd", 32'(akd), 32'h0);
        check("rst_enc_keycode", 32'(enc_keycode), 32'h0);
        Reset = 1'b0;
        tick();

        // Clean press of 'A'
        keycode = 8'd4;
        tick();
        check("cand_load", 32'(enc_keycode), 32'd4);
        ticks(DB - 1);
        check("press_not_early", 32'(kstrb), 32'h0);
        tick();
        check("press_kstrb", 32'(kstrb), 32'h1);
        check("press_akd", 32'(akd), 32'h1);
        check("press_data", 32'(kbd_data), 32'hC1);
        clear_strobe();
        check("clr_data", 32'(kbd_data), 32'h41);
        check("clr_akd", 32'(akd), 32'h1);
        settle(8'd0);
        check("release_akd", 32'(akd), 32'h0);

        // Bounce on '1' never commits
        keycode = 8'd30;
        ticks(2);
        keycode = 8'd0;
        ticks(6);
        check("bounce_kstrb", 32'(kstrb), 32'h0);
        check("bounce_akd", 32'(akd), 32'h0);
        check("bounce_data", 32'(kbd_data), 32'h41);

        // Enter held then released
        settle(8'd40);
        check("enter_data", 32'(kbd_data), 32'h8D);
        clear_strobe();
        keycode = 8'd0;
        ticks(DB);
        check("rel_akd_before", 32'(akd), 32'h1);
        tick();
        check("rel_akd_commit", 32'(akd), 32'h0);
        check("rel_data_kept", 32'(kbd_data), 32'h0D);
        keycode = 8'd100;
        ticks(10);
        check("unsup_kstrb", 32'(kstrb), 32'h0);
        check("unsup_akd", 32'(akd), 32'h0);
        settle(8'd0);

        // Roll-over from 'B' to 'C'
        settle(8'd5);
        check("b_data", 32'(kbd_data), 32'hC2);
        clear_strobe();
        check("b_clr", 32'(kbd_data), 32'h42);
        keycode = 8'd6;
        akd_dropped = 1'b0;
        for (int i = 0; i < DB; i++) begin
            tick();
            if (!akd) akd_dropped = 1'b1;
        end
        check("roll_not_early", 32'(kstrb), 32'h0);
        tick();
        if (!akd) akd_dropped = 1'b1;
        check("roll_kstrb", 32'(kstrb), 32'h1);
        check("roll_data", 32'(kbd_data), 32'hC3);
        check("roll_akd_held", 32'(akd_dropped), 32'h0);
        clear_strobe();
        settle(8'd0);

        // Clear on the commit edge of space: set wins
        keycode = 8'd44;
        ticks(DB);
        strb_clr = 1'b1;
        tick();
        strb_clr = 1'b0;
        check("setwin_kstrb", 32'(kstrb), 32'h1);
        check("setwin_data", 32'(kbd_data), 32'hA0);
        clear_strobe();
        clear_strobe();
        check("idle_clr_data", 32'(kbd_data), 32'h20);
        check("idle_clr_akd", 32'(akd), 32'h1);
        settle(8'd0);

        // Async reset during press debounce
        keycode = 8'd7;
        ticks(2);
        Reset = 1'b1;
        keycode = 8'd0;
        #1;
        check("areset_data", 32'(kbd_data), 32'h00);
        check("areset_akd", 32'(akd), 32'h0);
        check("areset_enc", 32'(enc_keycode), 32'h00);
        ticks(2);
        Reset = 1'b0;
        ticks(8);
        check("post_reset_kstrb", 32'(kstrb), 32'h0);
        check("post_reset_akd", 32'(akd), 32'h0);

        // Hold 'D' and collect strobes, clearing each one
        settle(8'd7);
        check("d_kstrb", 32'(kstrb), 32'h1);
        check("d_data", 32'(kbd_data), 32'hC4);
        strb_clr = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            strb_clr = 1'b0;
            if (kstrb) begin
                rep_edges.push_back(e);
                check("rep_data", 32'(kbd_data), 32'hC4);
                strb_clr = 1'b1;
            end
        end
        strb_clr = 1'b0;
`ifdef KBD_AUTOREPEAT_EN
        check("rep_count", 32'(rep_edges.size()), 32'd3);
        if (rep_edges.size() == 3) begin
            check("rep_first", 32'(rep_edges[0]), 32'd20);
            check("rep_second", 32'(rep_edges[1]), 32'd28);
            check("rep_third", 32'(rep_edges[2]), 32'd36);
        end
`else
        check("rep_count", 32'(rep_edges.size()), 32'd0);
`endif
        check("rep_akd", 32'(akd), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
